ob_rsp_egress: RTL and testbench
================================

// Module: ob_rsp_egress
// PURPOSE
//  Downstream of the order book: accepts ob_pkg::rsp_t responses on the valid/accept handshake.
//  Serialises each response into a byte-wide framed stream for the host link: SEQ, payload, checksum.
//  Holds one response at a time. Back-pressure from the link propagates to the order book by withholding rsp_accept.
// PARAMETERS
//  PAYLOAD_W   $bits(ob_pkg::rsp_t)   payload width in bits; zero-extended on the left to NBYTES*8
//  EN_CSUM     1                      1: append XOR checksum byte; 0: frame ends on last payload byte
// PORTS
//  clk          in   1             clock; single clock domain
//  rst          in   1             synchronous, active-high reset
//  rsp_vld      in   1             response valid from order book
//  rsp          in   PAYLOAD_W     response (ob_pkg::rsp_t packed)
//  rsp_accept   out  1             response consumed this cycle (rsp_vld & rsp_accept)
//  out_vld      out  1             byte valid on link
//  out_data     out  8             frame byte
//  out_sop      out  1             first byte of frame (SEQ)
//  out_eop      out  1             last byte of frame
//  out_accept   in   1             link takes byte this cycle (out_vld & out_accept)
//  frame_cnt_r  out  32            frames fully emitted since reset; wraps
// BEHAVIOUR
//  - NBYTES = ceil(PAYLOAD_W/8). FLEN = 1 + NBYTES + EN_CSUM.
//  - Frame: byte0 = seq_r[7:0]; bytes 1..NBYTES = padded payload, MSB byte first; last = XOR of bytes 0..NBYTES.
//  - FSM IDLE -> SEQ -> PAY -> CSUM -> IDLE. With EN_CSUM=0, PAY -> IDLE.
//  - IDLE: rsp_accept=1. On rsp_vld, capture payload into pay_r; go to SEQ next cycle.
//  - SEQ/PAY/CSUM: out_vld=1. A state or byte index advances only on out_accept.
//    out_data, out_sop, out_eop are held stable while out_vld & ~out_accept. Checked by assertion.
//  - Byte index: a counter of width $clog2(NBYTES+1) selects the payload byte in PAY. The payload byte is selected by a mux, not a shift register.
//  - Checksum: csum_r clears on entry to SEQ. It XORs in each byte as it is accepted. The CSUM state drives csum_r.
//  - Back-to-back: in the final-byte state, rsp_accept = out_accept. A response accepted there goes straight to SEQ, with no idle bubble.
//    Sustained throughput is FLEN cycles per response when out_accept=1.
//  - Latency: rsp accepted in cycle t -> out_vld with out_sop in cycle t+1.
//  - seq_r: 8 bits; increments on acceptance of the eop byte; wraps 0xFF -> 0x00.
//    frame_cnt_r: 32 bits; increments on the same event; wraps.
//  - rsp_accept is 0 in all non-final states. rsp_vld is ignored there, and the order book holds rsp.
//  - Reset values: state=IDLE, out_vld=0, out_sop=0, out_eop=0, out_data=0, rsp_accept=0 during rst.
//    rsp_accept=1 in the first cycle after rst deasserts. seq_r=0, frame_cnt_r=0, csum_r=0.
//  - Reset mid-frame: the frame is abandoned with no eop, and out_vld=0 from the next cycle. seq_r and the counters clear.
//  - out_sop and out_eop are never both 1, since FLEN >= 2 always.
// STRUCTURE
//  - ob_pkg: localparam OB_RSP_SEQ_W=8; typedef ob_egress_state_t {IDLE,SEQ,PAY,CSUM}; function ob_rsp_nbytes(w).
//  - One sub-module, ob_byte_sel: combinational PAYLOAD_W-to-byte mux indexed MSB-first. It is reused by the ingress side.
//  - Single always_ff for state, pay_r, idx, csum_r, seq_r, frame_cnt_r. Outputs are decoded from registered state.
// TESTING (instantiate with PAYLOAD_W=16 where values are given; also run default width)
//  1 Single frame, out_accept=1: rsp=16'hBEEF
//    -> bytes 00,BE,EF,51 over 4 cycles; sop on 00, eop on 51; seq_r=1, frame_cnt_r=1.
//  2 Stall: same stimulus, out_accept low 3 cycles on byte BE
//    -> BE held with out_vld=1 and data stable; frame completes unchanged.
//  3 Back-to-back: rsp_vld held with 16'h1234 then 16'h0000
//    -> frames 00,12,34,26 then 01,00,00,01 in 8 cycles; rsp_accept pulses on cycles 0 and 4.
//  4 Seq wrap: 256 frames of 16'h0001
//    -> frame 255 SEQ=FF, CSUM=FE; frame 256 SEQ=00; frame_cnt_r=256.
//  5 Reset mid-PAY, after the 00 byte is accepted: rst for 1 cycle
//    -> out_vld=0 the next cycle, no eop seen; the next rsp=16'hBEEF emits 00,BE,EF,51.
//  6 EN_CSUM=0, rsp=16'hA5A5 -> bytes 00,A5,A5; eop on the second A5; throughput 3 cycles per frame.

Source files
------------

// File: rtl/ob_pkg.sv
// ob_pkg: shared order-book response types and egress framing helpers.
package ob_pkg;
   localparam int OB_RSP_SEQ_W = 8;
   typedef enum logic [1:0] {IDLE, SEQ, PAY, CSUM} ob_egress_state_t;
   typedef struct packed {
      logic [3:0]  status;
      logic [15:0] order_id;
      logic [23:0] qty;
   } rsp_t;
   function automatic int ob_rsp_nbytes(input int w);
      return (w + 7) / 8;
   endfunction
endpackage

// File: rtl/ob_byte_sel.sv
// ob_byte_sel: picks byte idx (0 = most significant) of a left-zero-padded word.
module ob_byte_sel
   import ob_pkg::*;
#(
   parameter  int W  = 16,
   localparam int NB = ob_rsp_nbytes(W),
   localparam int IW = $clog2(NB + 1)
) (
   input  logic [W-1:0]  data,
   input  logic [IW-1:0] idx,
   output logic [7:0]    sel
);
   logic [NB*8-1:0] ext;
   assign ext = (NB*8)'(data);
   always_comb begin
      sel = '0;
      for (int i = 0; i < NB; i++)
         if (idx == IW'(NB - 1 - i)) sel = ext[8*i +: 8];
   end
endmodule

// File: rtl/ob_rsp_egress.sv
// ob_rsp_egress: serialises order-book responses into SEQ/payload/checksum byte frames.
module ob_rsp_egress
   import ob_pkg::*;
#(
   parameter int PAYLOAD_W = $bits(rsp_t),
   parameter bit EN_CSUM   = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rsp_vld,
   input  logic [PAYLOAD_W-1:0] rsp,
   output logic                 rsp_accept,
   output logic                 out_vld,
   output logic [7:0]           out_data,
   output logic                 out_sop,
   output logic                 out_eop,
   input  logic                 out_accept,
   output logic [31:0]          frame_cnt_r
);
   localparam int NBYTES = ob_rsp_nbytes(PAYLOAD_W);
   localparam int IW = $clog2(NBYTES + 1);
   localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);
   ob_egress_state_t state, state_nx;
   logic [PAYLOAD_W-1:0]    pay_r;
   logic [IW-1:0]           idx;
   logic [7:0]              csum_r, pay_byte;
   logic [OB_RSP_SEQ_W-1:0] seq_r;
   logic                    last, take, fire;
   ob_byte_sel #(.W(PAYLOAD_W)) u_sel (.data(pay_r), .idx(idx), .sel(pay_byte));
   // final-byte state is where a new response may be taken without a bubble
   assign last = (state == PAY && idx == LAST && !EN_CSUM) || state == CSUM;
   assign take = rsp_vld && rsp_accept;
   assign fire = out_vld && out_accept;
   always_comb begin
      out_vld    = state != IDLE;
      out_sop    = state == SEQ;
      out_eop    = last;
      out_data   = state == SEQ ? seq_r : state == PAY ? pay_byte : state == CSUM ? csum_r : 8'h00;
      rsp_accept = !rst && (state == IDLE || (last && out_accept));
      state_nx   = state == IDLE ? (take ? SEQ : IDLE) :
                   !out_accept ? state :
                   state == SEQ ? PAY :
                   (state == PAY && idx != LAST) ? PAY :
                   (state == PAY && EN_CSUM) ? CSUM :
                   take ? SEQ : IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         pay_r       <= '0;
         idx         <= '0;
         csum_r      <= '0;
         seq_r       <= '0;
         frame_cnt_r <= '0;
      end else begin
         state <= state_nx;
         if (fire) csum_r <= csum_r ^ out_data;
         if (fire && state == PAY) idx <= idx + 1'b1;
         if (fire && last) begin
            seq_r       <= seq_r + 1'b1;
            frame_cnt_r <= frame_cnt_r + 32'd1;
         end
         if (take) begin
            pay_r  <= rsp;
            idx    <= '0;
            csum_r <= '0;
         end
      end
   end
   // a stalled byte must not change under the link
   assert property (@(posedge clk) disable iff (rst)
      out_vld && !out_accept |=> out_vld && $stable(out_data) && $stable(out_sop) && $stable(out_eop));
endmodule

// File: tb/tb_ob_rsp_egress.sv
// tb_ob_rsp_egress: directed checks of framing, stalls, back-to-back, wrap, reset and no-checksum mode.
module tb_ob_rsp_egress;
   import ob_pkg::*;
   logic clk = 1'b0, rst = 1'b1;
   logic rv_a = 0, ra_a, ov_a, sop_a, eop_a, oa_a = 1;
   logic [15:0] rsp_a = '0;
   logic [7:0] od_a;
   logic [31:0] fc_a;
   logic rv_d = 0, ra_d, ov_d, sop_d, eop_d, oa_d = 1;
   rsp_t rsp_d = '0;
   logic [7:0] od_d;
   logic [31:0] fc_d;
   logic rv_n = 0, ra_n, ov_n, sop_n, eop_n, oa_n = 1;
   logic [15:0] rsp_n = '0;
   logic [7:0] od_n;
   logic [31:0] fc_n;
   int cyc = 0, checks = 0, failures = 0;
   logic [9:0] qa[$], qd[$], qn[$];
   int ca[$], cd[$], cn[$], aa[$], an[$];

   ob_rsp_egress #(.PAYLOAD_W(16)) u_a (.clk(clk), .rst(rst), .rsp_vld(rv_a), .rsp(rsp_a), .rsp_accept(ra_a),
      .out_vld(ov_a), .out_data(od_a), .out_sop(sop_a), .out_eop(eop_a), .out_accept(oa_a), .frame_cnt_r(fc_a));
   ob_rsp_egress u_d (.clk(clk), .rst(rst), .rsp_vld(rv_d), .rsp(rsp_d), .rsp_accept(ra_d),
      .out_vld(ov_d), .out_data(od_d), .out_sop(sop_d), .out_eop(eop_d), .out_accept(oa_d), .frame_cnt_r(fc_d));
   ob_rsp_egress #(.PAYLOAD_W(16), .EN_CSUM(1'b0)) u_n (.clk(clk), .rst(rst), .rsp_vld(rv_n), .rsp(rsp_n),
      .rsp_accept(ra_n), .out_vld(ov_n), .out_data(od_n), .out_sop(sop_n), .out_eop(eop_n), .out_accept(oa_n),
      .frame_cnt_r(fc_n));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (ov_a && oa_a) begin qa.push_back({sop_a, eop_a, od_a}); ca.push_back(cyc); end
      if (ov_d && oa_d) begin qd.push_back({sop_d, eop_d, od_d}); cd.push_back(cyc); end
      if (ov_n && oa_n) begin qn.push_back({sop_n, eop_n, od_n}); cn.push_back(cyc); end
      if (rv_a && ra_a) aa.push_back(cyc);
      if (rv_n && ra_n) an.push_back(cyc);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      rv_a = 0; rv_d = 0; rv_n = 0; oa_a = 1; oa_d = 1; oa_n = 1;
      tick;
      rst = 1'b0;
      qa.delete(); qd.delete(); qn.delete(); ca.delete(); cd.delete(); cn.delete(); aa.delete(); an.delete();
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick;
      tick;
      @(negedge clk);
      checks++;
      if ({ra_a, ov_a, sop_a, eop_a, od_a} !== 12'h000) begin
         failures++;
         $display("FAIL reset_outputs got acc/vld/sop/eop/data=%b%b%b%b/%h want 0000/00", ra_a, ov_a, sop_a, eop_a, od_a);
      end
      tick;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({ra_a, ra_d, ra_n, ov_a} !== 4'b1110 || fc_a !== 32'd0) begin
         failures++;
         $display("FAIL post_reset got acc=%b%b%b vld=%b cnt=%0d want acc=111 vld=0 cnt=0", ra_a, ra_d, ra_n, ov_a, fc_a);
      end
      tick;
   endtask

   task automatic test_single;
      logic [9:0] e[4] = '{10'h200, 10'h0BE, 10'h0EF, 10'h151};
      int k;
      do_reset;
      rsp_a = 16'hBEEF; rv_a = 1;
      k = cyc;
      tick;
      rv_a = 0;
      for (int i = 0; i < 20 && qa.size() < 4; i++) tick;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (i >= qa.size() || qa[i] !== e[i] || ca[i] !== k + 1 + i) begin
            failures++;
            $display("FAIL single_byte%0d got=%h@%0d want=%h@%0d", i, qa[i], ca[i], e[i], k + 1 + i);
         end
      end
      checks++;
      if (aa.size() !== 1 || aa[0] !== k || fc_a !== 32'd1 || u_a.seq_r !== 8'd1 || ov_a !== 1'b0) begin
         failures++;
         $display("FAIL single_counters got acc_n=%0d cnt=%0d seq=%h vld=%b want 1 1 01 0", aa.size(), fc_a, u_a.seq_r, ov_a);
      end
   endtask

   task automatic test_stall;
      logic [9:0] e[4] = '{10'h200, 10'h0BE, 10'h0EF, 10'h151};
      int off[4] = '{1, 5, 6, 7};
      int k;
      do_reset;
      rsp_a = 16'hBEEF; rv_a = 1;
      k = cyc;
      tick;
      rv_a = 0;
      tick;
      oa_a = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if ({ov_a, sop_a, eop_a, od_a} !== 11'h4BE) begin
            failures++;
            $display("FAIL stall_hold%0d got vld/sop/eop/data=%b%b%b/%h want 100/be", i, ov_a, sop_a, eop_a, od_a);
         end
         tick;
      end
      oa_a = 1;
      for (int i = 0; i < 20 && qa.size() < 4; i++) tick;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (i >= qa.size() || qa[i] !== e[i] || ca[i] !== k + off[i]) begin
            failures++;
            $display("FAIL stall_byte%0d got=%h@%0d want=%h@%0d", i, qa[i], ca[i], e[i], k + off[i]);
         end
      end
   endtask

   task automatic test_back_to_back;
      logic [9:0] e[8] = '{10'h200, 10'h012, 10'h034, 10'h126, 10'h201, 10'h000, 10'h000, 10'h101};
      int k;
      do_reset;
      rsp_a = 16'h1234; rv_a = 1;
      k = cyc;
      tick;
      rsp_a = 16'h0000;
      for (int i = 0; i < 20 && aa.size() < 2; i++) tick;
      rv_a = 0;
      for (int i = 0; i < 20 && qa.size() < 8; i++) tick;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (i >= qa.size() || qa[i] !== e[i] || ca[i] !== k + 1 + i) begin
            failures++;
            $display("FAIL b2b_byte%0d got=%h@%0d want=%h@%0d", i, qa[i], ca[i], e[i], k + 1 + i);
         end
      end
      checks++;
      if (aa.size() !== 2 || aa[0] !== k || aa[1] !== k + 4) begin
         failures++;
         $display("FAIL b2b_accept got n=%0d at %0d,%0d want 2 at %0d,%0d", aa.size(), aa[0], aa[1], k, k + 4);
      end
   endtask

   task automatic test_seq_wrap;
      logic [9:0] e[4] = '{10'h2FF, 10'h000, 10'h001, 10'h1FE};
      do_reset;
      rsp_a = 16'h0001; rv_a = 1;
      for (int i = 0; i < 1100 && aa.size() < 256; i++) tick;
      rv_a = 0;
      for (int i = 0; i < 20 && qa.size() < 1024; i++) tick;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (1020 + i >= qa.size() || qa[1020 + i] !== e[i]) begin
            failures++;
            $display("FAIL wrap_frame255_byte%0d got=%h want=%h", i, qa[1020 + i], e[i]);
         end
      end
      checks++;
      if (fc_a !== 32'd256 || u_a.seq_r !== 8'h00) begin
         failures++;
         $display("FAIL wrap_counters got cnt=%0d seq=%h want 256 00", fc_a, u_a.seq_r);
      end
      rv_a = 1;
      tick;
      rv_a = 0;
      for (int i = 0; i < 20 && qa.size() < 1025; i++) tick;
      checks++;
      if (qa.size() < 1025 || qa[1024] !== 10'h200) begin
         failures++;
         $display("FAIL wrap_frame256_seq got=%h want=200", qa[1024]);
      end
      for (int i = 0; i < 10; i++) tick;
   endtask

   task automatic test_reset_mid_frame;
      logic [9:0] e[4] = '{10'h200, 10'h0BE, 10'h0EF, 10'h151};
      int n;
      do_reset;
      rsp_a = 16'hBEEF; rv_a = 1;
      tick;
      rv_a = 0;
      tick;
      rst = 1; oa_a = 0;
      @(negedge clk);
      checks++;
      if (ra_a !== 1'b0) begin
         failures++;
         $display("FAIL midrst_accept_in_rst got=%b want=0", ra_a);
      end
      tick;
      rst = 0; oa_a = 1;
      @(negedge clk);
      checks++;
      if (ov_a !== 1'b0 || ra_a !== 1'b1 || fc_a !== 32'd0 || qa.size() !== 1 || qa[0][8] !== 1'b0) begin
         failures++;
         $display("FAIL midrst_abandon got vld=%b acc=%b cnt=%0d bytes=%0d want 0 1 0 1", ov_a, ra_a, fc_a, qa.size());
      end
      tick;
      n = qa.size();
      rsp_a = 16'hBEEF; rv_a = 1;
      tick;
      rv_a = 0;
      for (int i = 0; i < 20 && qa.size() < n + 4; i++) tick;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (n + i >= qa.size() || qa[n + i] !== e[i]) begin
            failures++;
            $display("FAIL midrst_byte%0d got=%h want=%h", i, qa[n + i], e[i]);
         end
      end
   endtask

   task automatic test_no_csum;
      logic [9:0] e[6] = '{10'h200, 10'h0A5, 10'h1A5, 10'h201, 10'h0A5, 10'h1A5};
      int k;
      do_reset;
      rsp_n = 16'hA5A5; rv_n = 1;
      k = cyc;
      tick;
      for (int i = 0; i < 20 && an.size() < 2; i++) tick;
      rv_n = 0;
      for (int i = 0; i < 20 && qn.size() < 6; i++) tick;
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (i >= qn.size() || qn[i] !== e[i] || cn[i] !== k + 1 + i) begin
            failures++;
            $display("FAIL nocsum_byte%0d got=%h@%0d want=%h@%0d", i, qn[i], cn[i], e[i], k + 1 + i);
         end
      end
      checks++;
      if (an.size() !== 2 || an[1] !== k + 3 || fc_n !== 32'd2) begin
         failures++;
         $display("FAIL nocsum_rate got n=%0d second=%0d cnt=%0d want 2 %0d 2", an.size(), an[1], fc_n, k + 3);
      end
   endtask

   task automatic test_default_width;
      logic [9:0] e[8] = '{10'h200, 10'h00A, 10'h012, 10'h034, 10'h056, 10'h078, 10'h09A, 10'h198};
      int k;
      do_reset;
      rsp_d = '{status: 4'hA, order_id: 16'h1234, qty: 24'h56789A};
      rv_d = 1;
      k = cyc;
      tick;
      rv_d = 0;
      for (int i = 0; i < 20 && qd.size() < 8; i++) tick;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (i >= qd.size() || qd[i] !== e[i] || cd[i] !== k + 1 + i) begin
            failures++;
            $display("FAIL default_byte%0d got=%h@%0d want=%h@%0d", i, qd[i], cd[i], e[i], k + 1 + i);
         end
      end
      checks++;
      if (fc_d !== 32'd1) begin
         failures++;
         $display("FAIL default_count got=%0d want=1", fc_d);
      end
   endtask

   initial begin
      test_reset;
      test_single;
      test_stall;
      test_back_to_back;
      test_seq_wrap;
      test_reset_mid_frame;
      test_no_csum;
      test_default_width;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
